// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write-source tags and load-queue entry type for wb_arbiter
package wb_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LOAD} wb_src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } lq_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// ctrl_bus_if: clock and asynchronous active-high reset distributed to the write-back block
interface ctrl_bus_if;
    logic clk;
    logic reset;
    modport master (output clk, reset);
    modport central (input clk, reset);
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: load-return FIFO; pointers wrap modulo DEPTH, push and pop together keep count
module wb_fifo
    import wb_pkg::*;
#(
    parameter type T     = lq_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  T                             din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output T                             head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    T mem [DEPTH];
    logic [PW-1:0] wp, rp;
    // read/write pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + PW'(push);
            rp <= rp + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage is never read outside the live window, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rp];
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load-return writes onto the regfile write port and tracks pending loads
// Build option WB_FORWARD_EN: adds write-port forwarding outputs and drops the write-port stall term
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    ctrl_bus_if.central                      ctrl_bus,
    input  logic                             alu_valid,
    output logic                             alu_ready,
    input  logic [ADDR_W-1:0]                alu_rd,
    input  logic [DATA_W-1:0]                alu_data,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [ADDR_W-1:0]                ld_rd,
    input  logic [DATA_W-1:0]                ld_data,
    input  logic                             issue_valid,
    input  logic [ADDR_W-1:0]                issue_rd,
    input  logic [ADDR_W-1:0]                rs,
    input  logic [ADDR_W-1:0]                rt,
    output logic                             rs_busy,
    output logic                             rt_busy,
    output logic                             reg_write,
    output logic [ADDR_W-1:0]                rd,
    output logic [DATA_W-1:0]                reg_in,
    output logic [$clog2(LQ_DEPTH+1)-1:0]    lq_count
`ifdef WB_FORWARD_EN
    ,
    output logic                             rs_fwd_valid,
    output logic [DATA_W-1:0]                rs_fwd_data,
    output logic                             rt_fwd_valid,
    output logic [DATA_W-1:0]                rt_fwd_data
`endif
);
    logic full, empty, push, pop;
    lq_entry_t head;
    wb_src_e sel, src;
    logic [NUM_REGS-1:0] pending, set, clr;
    logic rs_wp, rt_wp;
    logic unused_hi;

    assign alu_ready = !full;
    assign ld_ready = !full;
    assign push = ld_valid && !full && ld_rd[IDX_W-1:0] != '0;
    assign sel = full ? WB_LOAD
               : (alu_valid && alu_rd[IDX_W-1:0] != '0) ? WB_ALU
               : !empty ? WB_LOAD : WB_NONE;
    assign pop = sel == WB_LOAD;

    wb_fifo #(.T(lq_entry_t), .DEPTH(LQ_DEPTH)) u_fifo (
        .clk   (ctrl_bus.clk),
        .rst   (ctrl_bus.reset),
        .push  (push),
        .pop   (pop),
        .din   (lq_entry_t'({ld_rd, ld_data})),
        .full  (full),
        .empty (empty),
        .count (lq_count),
        .head  (head)
    );

    // registered write port: the source picked this cycle is presented next cycle
    always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
        if (ctrl_bus.reset) begin
            reg_write <= 1'b0;
            rd <= '0;
            reg_in <= '0;
            src <= WB_NONE;
        end else begin
            reg_write <= sel != WB_NONE;
            src <= sel;
            rd <= sel == WB_ALU ? alu_rd : sel == WB_LOAD ? head.rd : '0;
            reg_in <= sel == WB_ALU ? alu_data : sel == WB_LOAD ? head.data : '0;
        end
    end

    assign set = (NUM_REGS'(issue_valid) << issue_rd[IDX_W-1:0]) & ~NUM_REGS'(1);
    assign clr = NUM_REGS'(reg_write && src == WB_LOAD) << rd[IDX_W-1:0];

    // scoreboard: a new issue outranks the clear from a load leaving the write port
    always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
        if (ctrl_bus.reset) pending <= '0;
        else pending <= (pending & ~clr) | set;
    end

`ifdef WB_FORWARD_EN
    assign rs_wp = 1'b0;
    assign rt_wp = 1'b0;
    assign rs_fwd_valid = reg_write && rd[IDX_W-1:0] == rs[IDX_W-1:0] && rs[IDX_W-1:0] != '0;
    assign rt_fwd_valid = reg_write && rd[IDX_W-1:0] == rt[IDX_W-1:0] && rt[IDX_W-1:0] != '0;
    assign rs_fwd_data = reg_in;
    assign rt_fwd_data = reg_in;
`else
    assign rs_wp = reg_write && rd[IDX_W-1:0] == rs[IDX_W-1:0];
    assign rt_wp = reg_write && rd[IDX_W-1:0] == rt[IDX_W-1:0];
`endif
    assign rs_busy = rs[IDX_W-1:0] != '0 && (pending[rs[IDX_W-1:0]] || rs_wp);
    assign rt_busy = rt[IDX_W-1:0] != '0 && (pending[rt[IDX_W-1:0]] || rt_wp);
    assign unused_hi = ^{rs[ADDR_W-1:IDX_W], rt[ADDR_W-1:IDX_W], issue_rd[ADDR_W-1:IDX_W]};
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based reference model
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_pkg::*;
    localparam int LQ_DEPTH = 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    ctrl_bus_if cb();
    logic alu_valid, alu_ready, ld_valid, ld_ready, issue_valid;
    logic rs_busy, rt_busy, reg_write;
    logic [ADDR_W-1:0] alu_rd, ld_rd, issue_rd, rs, rt, rd;
    logic [DATA_W-1:0] alu_data, ld_data, reg_in;
    logic [2:0] lq_count;
`ifdef WB_FORWARD_EN
    logic rs_fwd_valid, rt_fwd_valid;
    logic [DATA_W-1:0] rs_fwd_data, rt_fwd_data;
`endif

    wb_arbiter #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .ctrl_bus    (cb),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs          (rs),
        .rt          (rt),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .reg_write   (reg_write),
        .rd          (rd),
        .reg_in      (reg_in),
        .lq_count    (lq_count)
`ifdef WB_FORWARD_EN
        ,
        .rs_fwd_valid (rs_fwd_valid),
        .rs_fwd_data  (rs_fwd_data),
        .rt_fwd_valid (rt_fwd_valid),
        .rt_fwd_data  (rt_fwd_data)
`endif
    );

    // reference model: queue of buffered loads, pending flags, and the expected write port
    lq_entry_t q[$];
    bit pend [NUM_REGS];
    bit m_wr, m_ld;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;
    int compared = 0;
    int mismatched = 0;

    initial cb.clk = 1'b0;
    always #5 cb.clk = ~cb.clk;

    function automatic bit exp_busy(logic [ADDR_W-1:0] s);
        int i;
        i = int'(s[IDX_W-1:0]);
        return i != 0 && (pend[i] || (!FWD && m_wr && m_rd[IDX_W-1:0] == s[IDX_W-1:0]));
    endfunction

    task automatic model_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_wr = 1'b0;
        m_ld = 1'b0;
        m_rd = '0;
        m_data = '0;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid = 0; ld_rd = '0; ld_data = '0;
        issue_valid = 0; issue_rd = '0;
        rs = '0; rt = '0;
    endtask

    // one clock: the model applies the rules to the inputs present at the edge
    task automatic tick();
        bit full, alu_ok;
        lq_entry_t w;
        @(posedge cb.clk);
        full = q.size() == LQ_DEPTH;
        alu_ok = alu_valid && alu_rd[IDX_W-1:0] != 0;
        if (m_wr && m_ld) pend[m_rd[IDX_W-1:0]] = 1'b0;
        if (issue_valid && issue_rd[IDX_W-1:0] != 0) pend[issue_rd[IDX_W-1:0]] = 1'b1;
        m_wr = 0; m_ld = 0; m_rd = '0; m_data = '0;
        if (full || (!alu_ok && q.size() > 0)) begin
            w = q.pop_front();
            m_wr = 1; m_ld = 1; m_rd = w.rd; m_data = w.data;
        end else if (alu_ok) begin
            m_wr = 1; m_rd = alu_rd; m_data = alu_data;
        end
        if (ld_valid && !full && ld_rd[IDX_W-1:0] != 0) q.push_back(lq_entry_t'({ld_rd, ld_data}));
        #1;
    endtask

    task automatic test_reset();
        idle();
        cb.reset = 1'b1;
        model_reset();
        repeat (2) @(posedge cb.clk);
        #1;
        compared++;
        if ({reg_write, rd, reg_in, lq_count, rs_busy, rt_busy, ld_ready, alu_ready} !== {1'b0, 6'd0, 32'd0, 3'd0, 4'b0011}) begin
            mismatched++;
            $display("FAIL reset_state: got %b %h %h %0d %b%b%b%b want 0 00 00000000 0 0011", reg_write, rd, reg_in, lq_count, rs_busy, rt_busy, ld_ready, alu_ready);
        end
        cb.reset = 1'b0;
    endtask

    task automatic test_alu_write();
        alu_valid = 1; alu_rd = 6'd5; alu_data = 32'h1234;
        tick();
        idle();
        compared++;
        if ({reg_write, rd, reg_in} !== {1'b1, 6'd5, 32'h1234}) begin
            mismatched++;
            $display("FAIL alu_write: got %b rd=%0d data=%h want 1 rd=5 data=1234", reg_write, rd, reg_in);
        end
        tick();
        compared++;
        if (reg_write !== 1'b0) begin
            mismatched++;
            $display("FAIL alu_write_idle: got reg_write=%b want 0", reg_write);
        end
    endtask

    task automatic test_load_hazard();
        issue_valid = 1; issue_rd = 6'd7; rs = 6'd7;
        tick();
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (rs_busy !== 1'b1) begin
                mismatched++;
                $display("FAIL hazard_wait%0d: got rs_busy=%b want 1", i, rs_busy);
            end
            if (i < 2) tick();
        end
        ld_valid = 1; ld_rd = 6'd7; ld_data = 32'hCAFE;
        tick();
        ld_valid = 0;
        compared++;
        if ({lq_count, rs_busy} !== {3'd1, 1'b1}) begin
            mismatched++;
            $display("FAIL hazard_queued: got count=%0d busy=%b want 1 1", lq_count, rs_busy);
        end
        tick();
        compared++;
        if ({reg_write, rd, reg_in, rs_busy} !== {1'b1, 6'd7, 32'hCAFE, 1'b1}) begin
            mismatched++;
            $display("FAIL hazard_write: got %b rd=%0d data=%h busy=%b want 1 7 cafe 1", reg_write, rd, reg_in, rs_busy);
        end
        tick();
        compared++;
        if ({reg_write, rs_busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL hazard_clear: got reg_write=%b busy=%b want 0 0", reg_write, rs_busy);
        end
        idle();
    endtask

    task automatic test_full_fifo();
        alu_valid = 1; alu_rd = 6'd10; ld_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ld_rd = 6'(11 + i); ld_data = $urandom(); alu_data = 32'(i);
            tick();
        end
        ld_valid = 0;
        compared++;
        if ({lq_count, alu_ready, ld_ready, rd} !== {3'd4, 2'b00, 6'd10}) begin
            mismatched++;
            $display("FAIL full_state: got count=%0d alu_rdy=%b ld_rdy=%b rd=%0d want 4 0 0 10", lq_count, alu_ready, ld_ready, rd);
        end
        tick();
        compared++;
        if ({reg_write, rd, reg_in, lq_count, alu_ready} !== {1'b1, 6'd11, m_data, 3'd3, 1'b1}) begin
            mismatched++;
            $display("FAIL full_pop: got %b rd=%0d data=%h count=%0d rdy=%b want 1 11 %h 3 1", reg_write, rd, reg_in, lq_count, alu_ready, m_data);
        end
        tick();
        compared++;
        if ({reg_write, rd, reg_in} !== {1'b1, 6'd10, 32'd3}) begin
            mismatched++;
            $display("FAIL full_alu_resume: got %b rd=%0d data=%h want 1 10 3", reg_write, rd, reg_in);
        end
        alu_valid = 0;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            tick();
            compared++;
            if ({reg_write, rd, reg_in} !== {m_wr, m_rd, m_data}) begin
                mismatched++;
                $display("FAIL full_drain%0d: got %b rd=%0d data=%h want %b %0d %h", i, reg_write, rd, reg_in, m_wr, m_rd, m_data);
            end
        end
        compared++;
        if (lq_count !== 3'd0) begin
            mismatched++;
            $display("FAIL full_drained: got count=%0d want 0", lq_count);
        end
        idle();
    endtask

    task automatic test_rd_zero();
        ld_valid = 1; ld_rd = 6'd3; ld_data = 32'h33;
        tick();
        ld_valid = 0;
        alu_valid = 1; alu_rd = 6'd0; alu_data = 32'hDEAD;
        compared++;
        if ({lq_count, alu_ready} !== {3'd1, 1'b1}) begin
            mismatched++;
            $display("FAIL rd0_setup: got count=%0d alu_rdy=%b want 1 1", lq_count, alu_ready);
        end
        tick();
        alu_valid = 0;
        compared++;
        if ({reg_write, rd, reg_in, lq_count} !== {1'b1, 6'd3, 32'h33, 3'd0}) begin
            mismatched++;
            $display("FAIL rd0_alu_pop: got %b rd=%0d data=%h count=%0d want 1 3 33 0", reg_write, rd, reg_in, lq_count);
        end
        ld_valid = 1; ld_rd = 6'd0; ld_data = 32'h77;
        compared++;
        if (ld_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rd0_ld_ready: got %b want 1", ld_ready);
        end
        tick();
        ld_valid = 0;
        tick();
        compared++;
        if ({reg_write, lq_count} !== {1'b0, 3'd0}) begin
            mismatched++;
            $display("FAIL rd0_load_dropped: got %b count=%0d want 0 0", reg_write, lq_count);
        end
    endtask

    task automatic test_collision();
        issue_valid = 1; issue_rd = 6'd9; rs = 6'd9;
        tick();
        issue_valid = 0;
        ld_valid = 1; ld_rd = 6'd9; ld_data = $urandom();
        tick();
        ld_valid = 0;
        tick();
        compared++;
        if ({reg_write, rd, rs_busy} !== {1'b1, 6'd9, 1'b1}) begin
            mismatched++;
            $display("FAIL collide_write: got %b rd=%0d busy=%b want 1 9 1", reg_write, rd, rs_busy);
        end
        issue_valid = 1; issue_rd = 6'd9;
        tick();
        issue_valid = 0;
        compared++;
        if ({reg_write, rs_busy} !== {1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL collide_set_wins: got reg_write=%b busy=%b want 0 1", reg_write, rs_busy);
        end
        tick();
        compared++;
        if (rs_busy !== exp_busy(rs)) begin
            mismatched++;
            $display("FAIL collide_hold: got busy=%b want %b", rs_busy, exp_busy(rs));
        end
        idle();
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_rd = 6'd20;
        tick();
        issue_rd = 6'd21;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 6'd5; ld_valid = 1; ld_rd = 6'd22;
        tick();
        ld_rd = 6'd23;
        tick();
        ld_valid = 0;
        rs = 6'd20; rt = 6'd21;
        #1;
        compared++;
        if ({lq_count, rs_busy, rt_busy, reg_write} !== {3'd2, 3'b111}) begin
            mismatched++;
            $display("FAIL midreset_setup: got count=%0d busy=%b%b wr=%b want 2 11 1", lq_count, rs_busy, rt_busy, reg_write);
        end
        #1 cb.reset = 1'b1;
        #1;
        compared++;
        if ({reg_write, rd, reg_in, lq_count, rs_busy, rt_busy, ld_ready, alu_ready} !== {1'b0, 6'd0, 32'd0, 3'd0, 4'b0011}) begin
            mismatched++;
            $display("FAIL midreset_async: got %b %h %h %0d %b%b%b%b want 0 00 00000000 0 0011", reg_write, rd, reg_in, lq_count, rs_busy, rt_busy, ld_ready, alu_ready);
        end
        model_reset();
        idle();
        rs = 6'd20; rt = 6'd22;
        @(posedge cb.clk);
        #1 cb.reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if ({reg_write, lq_count, rs_busy, rt_busy} !== {1'b0, 3'd0, 2'b00}) begin
                mismatched++;
                $display("FAIL midreset_after%0d: got wr=%b count=%0d busy=%b%b want 0 0 00", i, reg_write, lq_count, rs_busy, rt_busy);
            end
        end
        idle();
    endtask

    task automatic test_write_port();
        alu_valid = 1; alu_rd = 6'd4; alu_data = 32'hF00D; rs = 6'd4; rt = 6'd5;
        tick();
        alu_valid = 0;
`ifdef WB_FORWARD_EN
        compared++;
        if ({rs_fwd_valid, rs_fwd_data, rs_busy, rt_fwd_valid} !== {1'b1, 32'hF00D, 2'b00}) begin
            mismatched++;
            $display("FAIL fwd_rs: got v=%b d=%h busy=%b rt_v=%b want 1 f00d 0 0", rs_fwd_valid, rs_fwd_data, rs_busy, rt_fwd_valid);
        end
`else
        compared++;
        if ({rs_busy, rt_busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL wp_stall: got busy=%b%b want 10", rs_busy, rt_busy);
        end
`endif
        tick();
        compared++;
        if (rs_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL wp_stall_end: got busy=%b want 0", rs_busy);
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alu_valid = $urandom_range(0, 9) < 6;
            alu_rd = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 31));
            alu_data = $urandom();
            ld_valid = $urandom_range(0, 9) < 5;
            ld_rd = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 31));
            ld_data = $urandom();
            issue_valid = $urandom_range(0, 3) == 0;
            issue_rd = 6'($urandom_range(0, 31));
            rs = 6'($urandom_range(0, 31));
            rt = 6'($urandom_range(0, 31));
            tick();
            compared++;
            if ({reg_write, lq_count, ld_ready, alu_ready} !== {m_wr, 3'(q.size()), q.size() != LQ_DEPTH, q.size() != LQ_DEPTH}) begin
                mismatched++;
                $display("FAIL rnd_ctrl c=%0d: got wr=%b count=%0d rdy=%b%b want %b %0d", c, reg_write, lq_count, ld_ready, alu_ready, m_wr, q.size());
            end
            if (m_wr) begin
                compared++;
                if ({rd, reg_in} !== {m_rd, m_data}) begin
                    mismatched++;
                    $display("FAIL rnd_port c=%0d: got rd=%0d data=%h want %0d %h", c, rd, reg_in, m_rd, m_data);
                end
            end
            compared++;
            if ({rs_busy, rt_busy} !== {exp_busy(rs), exp_busy(rt)}) begin
                mismatched++;
                $display("FAIL rnd_busy c=%0d: got %b%b want %b%b rs=%0d rt=%0d", c, rs_busy, rt_busy, exp_busy(rs), exp_busy(rt), rs, rt);
            end
`ifdef WB_FORWARD_EN
            compared++;
            if (rs_fwd_valid !== (m_wr && m_rd[IDX_W-1:0] == rs[IDX_W-1:0] && rs[IDX_W-1:0] != 0)) begin
                mismatched++;
                $display("FAIL rnd_fwd c=%0d: got %b rs=%0d port_rd=%0d", c, rs_fwd_valid, rs, m_rd);
            end
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_hazard();
        test_full_fifo();
        test_rd_zero();
        test_collision();
        test_reset_mid();
        test_write_port();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side partner of the register file: collects destination writes from the ALU (single-cycle) and the load unit (variable latency) and drives the regfile write port.
- Buffers load returns in a small FIFO and arbitrates ALU vs. load.
- Keeps a pending-load scoreboard so decode can stall on RAW hazards against outstanding loads.
- Sits between execute/memory and the regfile in the datapath.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 6, register address width; only indices 0..31 are architectural, bits above [4:0] are ignored.
- NUM_REGS, 32, architectural register count.
- LQ_DEPTH, 4, load-return FIFO depth (power of two, ≥2).

Ports:
- ctrl_bus  in  ctrl_bus_if.central  supplies clk and reset. One clock, ctrl_bus.clk. Reset is ctrl_bus.reset, asynchronous and active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_W  ALU destination.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load return present.
- ld_ready  out  1  FIFO can accept.
- ld_rd  in  ADDR_W  load destination.
- ld_data  in  DATA_W  load data.
- issue_valid  in  1  load issued; mark destination pending.
- issue_rd  in  ADDR_W  destination of the issued load.
- rs, rt  in  ADDR_W  decode source queries.
- rs_busy, rt_busy  out  1  source has an outstanding hazard.
- reg_write  out  1  regfile write enable.
- rd  out  ADDR_W  regfile write address.
- reg_in  out  DATA_W  regfile write data.
- lq_count  out  $clog2(LQ_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, mid-operation included):
  - FIFO emptied and scoreboard cleared.
  - reg_write=0, rd=0, reg_in=0, lq_count=0, busy=0.
  - ld_ready=1, alu_ready=1 immediately.
- Write port: reg_write, rd and reg_in are registered. A source selected in cycle N appears on the port in cycle N+1, and the regfile commits at the end of N+1.
- Ready signals (derived from registered count, no combinational path from valids):
  - ld_ready = (lq_count != LQ_DEPTH).
  - alu_ready = (lq_count != LQ_DEPTH).
- Arbitration per cycle, first match wins:
  1. FIFO full → pop head; ALU is held off via alu_ready=0.
  2. alu_valid && alu_rd!=0 → write ALU.
  3. FIFO non-empty → pop head.
  4. Otherwise reg_write=0 next cycle.
- Writes to rd==0:
  - ALU with alu_rd==0 is accepted and dropped; rule 3 may pop in the same cycle.
  - Load with ld_rd==0 is handshaken (ld_valid&&ld_ready) but never enqueued.
- FIFO:
  - Enqueue on ld_valid&&ld_ready; pop as above.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- Scoreboard (one bit per register):
  - Set on issue_valid with issue_rd!=0.
  - Cleared in the cycle the load write appears on the port (reg_write from a load source, at the end of that cycle).
  - Same-cycle set and clear of the same register: set wins.
  - Bit 0 is never set.
- rs_busy = rs!=0 && (pending[rs] || hazard on the write port). rt_busy likewise.
- ALU writes never touch the scoreboard.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined:
  - Adds outputs rs_fwd_valid, rs_fwd_data, rt_fwd_valid, rt_fwd_data (1/DATA_W).
  - rs_fwd_valid = reg_write && rd==rs && rs!=0, and rs_fwd_data = reg_in; rt likewise.
  - The write-port term is removed from the busy outputs.
- Not defined:
  - No forwarding ports.
  - The busy outputs include the term (reg_write && rd==src), so decode stalls one cycle.

Decomposition:
- Package wb_pkg:
  - DATA_W, ADDR_W, NUM_REGS.
  - typedef enum wb_src_e {WB_NONE, WB_ALU, WB_LOAD}.
  - typedef struct lq_entry_t {rd, data}.
- Sub-module wb_fifo (parameterised on lq_entry_t and LQ_DEPTH):
  - Ports: push, pop, full, empty, count, head.
  - Instantiated once.

Test Plan:
1. Basic ALU write: alu_valid=1, alu_rd=5, alu_data=32'h1234 at cycle 0 → cycle 1 reg_write=1, rd=5, reg_in=32'h1234; cycle 2 reg_write=0.
2. Load hazard clear: issue rd=7, then ld return rd=7, data=32'hCAFE after 3 cycles with alu idle → rs=7 gives rs_busy=1 until the cycle reg_write=1/rd=7 ends; rs_busy=0 the cycle after.
3. Full FIFO: 4 load returns with continuous alu_valid → lq_count=4, alu_ready=0 and ld_ready=0; next cycle a load head is written; ALU writes resume when lq_count drops to 3.
4. rd zero: alu_rd=0 with one queued load rd=3 → same cycle pops the load; next cycle rd=3. ld_rd=0 return → lq_count unchanged.
5. Set/clear collision: issue_valid rd=9 in the same cycle a load rd=9 writes → pending[9] stays 1, rs_busy=1.
6. Reset mid-operation: reset with lq_count=2 and pending bits set → outputs zero asynchronously; after release no stale writes and all busy=0. With WB_FORWARD_EN, reg_write rd=4 and rs=4 → rs_fwd_valid=1, rs_busy=0.
